irq_return: RTL and testbench

- Interrupt-exit sequencer; the counterpart of the interrupt-entry block.
- On a return-from-interrupt request it takes the CPU instruction path and injects a fixed two-word sequence: increment SP, then pop PC.
- It then acknowledges the retired source to the peripheral side with a one-hot pulse.
- It keeps a small in-service stack of interrupt IDs so nested interrupts retire in LIFO order.

---
 rtl/irq_pkg.sv | 32 +++
 rtl/irq_id_stack.sv | 66 ++++++
 rtl/irq_return.sv | 106 ++++++++++
 tb/tb_irq_return.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt entry/exit sequencers: ID widths,
// injected instruction-word encodings, exit FSM states and helpers.
package irq_pkg;

    localparam int NUM_IRQ  = 8;
    localparam int IRQ_ID_W = 3;
    localparam int INSTR_W  = 29;

    // Words injected by the exit sequencer.
    localparam logic [INSTR_W-1:0] INC_SP_ENC  = 29'h0110_0001;
    localparam logic [INSTR_W-1:0] POP_PC_ENC  = 29'h0220_0002;
    localparam logic [INSTR_W-1:0] NOP_ENC     = 29'h0000_0000;

    // Words injected by the entry sequencer (kept here so both sides agree).
    localparam logic [INSTR_W-1:0] PUSH_PC_ENC = 29'h0330_0003;
    localparam logic [INSTR_W-1:0] DEC_SP_ENC  = 29'h0440_0004;
    localparam logic [INSTR_W-1:0] JUMP_ENC    = 29'h0550_0005;

    // Exit sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INC_SP = 2'd1,
        POP_PC = 2'd2,
        ACK    = 2'd3
    } ret_state_e;

    // One-hot acknowledge vector for an interrupt ID.
    function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
        id_onehot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/irq_id_stack.sv
// In-service interrupt ID stack. A pop and a push in the same cycle are
// applied in that order, so the pushed ID lands in the slot just freed.
// A push into a full stack is dropped and latches the overflow flag.
module irq_id_stack
    import irq_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                push,
    input  logic [IRQ_ID_W-1:0] push_id,
    input  logic                pop,
    output logic [IRQ_ID_W-1:0] top,
    output logic [LVL_W-1:0]    level,
    output logic                overflow
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [IRQ_ID_W-1:0] mem [DEPTH];
    logic [LVL_W-1:0]    lvl_after_pop;
    logic [LVL_W-1:0]    top_slot;
    logic                push_ok;

    // Level after the (guarded) pop, and whether a push still fits.
    always_comb begin
        lvl_after_pop = level;
        if (pop && (level != {LVL_W{1'b0}})) begin
            lvl_after_pop = level - {{(LVL_W-1){1'b0}}, 1'b1};
        end else begin
            lvl_after_pop = level;
        end
        push_ok  = push && (lvl_after_pop < FULL_LVL);
        top_slot = level - {{(LVL_W-1){1'b0}}, 1'b1};
    end

    assign top = mem[top_slot[IDX_W-1:0]];

    // Fill level and sticky overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level    <= {LVL_W{1'b0}};
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                level <= lvl_after_pop + {{(LVL_W-1){1'b0}}, 1'b1};
            end else begin
                level <= lvl_after_pop;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stack storage; contents need no reset since level gates every read.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[lvl_after_pop[IDX_W-1:0]] <= push_id;
        end
    end

endmodule

// File: rtl/irq_return.sv
// Interrupt-exit sequencer. On RETI it overrides the fetch path with
// INC_SP then POP_PC, then pulses a one-hot acknowledge for the retired
// (top-of-stack) ID. Every output is registered on entry to its state.
module irq_return
    import irq_pkg::*;
#(
    parameter int                 DEPTH       = 4,
    parameter logic [INSTR_W-1:0] INC_SP_WORD = INC_SP_ENC,
    parameter logic [INSTR_W-1:0] POP_PC_WORD = POP_PC_ENC,
    parameter logic [INSTR_W-1:0] NOP_WORD    = NOP_ENC,
    localparam int                LVL_W       = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                irq_entered,
    input  logic [IRQ_ID_W-1:0] irq_id,
    input  logic                reti_req,
    output logic [INSTR_W-1:0]  Instruction,
    output logic                inject,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic [LVL_W-1:0]    nest_level,
    output logic                busy,
    output logic                spurious,
    output logic                overflow
);

    ret_state_e          state;
    logic [IRQ_ID_W-1:0] top_id;
    logic                pop;

    // The pop happens on the edge that enters ACK, together with irq_ack.
    assign pop = (state == POP_PC);

    irq_id_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .CLK      (CLK),
        .RST      (RST),
        .push     (irq_entered),
        .push_id  (irq_id),
        .pop      (pop),
        .top      (top_id),
        .level    (nest_level),
        .overflow (overflow)
    );

    // Exit FSM with registered instruction, inject, ack, busy and spurious.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            Instruction <= NOP_WORD;
            inject      <= 1'b0;
            irq_ack     <= {NUM_IRQ{1'b0}};
            busy        <= 1'b0;
            spurious    <= 1'b0;
        end else begin
            irq_ack  <= {NUM_IRQ{1'b0}};
            spurious <= 1'b0;
            case (state)
                IDLE: begin
                    if (reti_req && (nest_level != {LVL_W{1'b0}})) begin
                        state       <= INC_SP;
                        Instruction <= INC_SP_WORD;
                        inject      <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        // Nothing in service: a RETI here is ignored.
                        spurious    <= reti_req;
                        Instruction <= NOP_WORD;
                        inject      <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                INC_SP: begin
                    state       <= POP_PC;
                    Instruction <= POP_PC_WORD;
                    inject      <= 1'b1;
                    busy        <= 1'b1;
                    spurious    <= reti_req;
                end
                POP_PC: begin
                    state       <= ACK;
                    Instruction <= NOP_WORD;
                    inject      <= 1'b0;
                    busy        <= 1'b1;
                    irq_ack     <= id_onehot(top_id);
                    spurious    <= reti_req;
                end
                ACK: begin
                    state       <= IDLE;
                    Instruction <= NOP_WORD;
                    inject      <= 1'b0;
                    busy        <= 1'b0;
                    spurious    <= reti_req;
                end
                default: begin
                    state       <= IDLE;
                    Instruction <= NOP_WORD;
                    inject      <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_return.sv
// Directed bench for irq_return: an abstract model (queue of IDs plus a
// phase count of the exit sequence) is compared with the DUT every cycle,
// and hand-computed literals pin the key points of each scenario.
module tb_irq_return;

    localparam int          DEPTH = 4;
    localparam logic [28:0] W_INC = 29'h1234567;
    localparam logic [28:0] W_POP = 29'h0BCDEF1;
    localparam logic [28:0] W_NOP = 29'h0000013;

    logic        CLK;
    logic        RST;
    logic        irq_entered;
    logic [2:0]  irq_id;
    logic        reti_req;
    logic [28:0] Instruction;
    logic        inject;
    logic [7:0]  irq_ack;
    logic [2:0]  nest_level;
    logic        busy;
    logic        spurious;
    logic        overflow;

    irq_return #(
        .DEPTH       (DEPTH),
        .INC_SP_WORD (W_INC),
        .POP_PC_WORD (W_POP),
        .NOP_WORD    (W_NOP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .irq_entered (irq_entered),
        .irq_id      (irq_id),
        .reti_req    (reti_req),
        .Instruction (Instruction),
        .inject      (inject),
        .irq_ack     (irq_ack),
        .nest_level  (nest_level),
        .busy        (busy),
        .spurious    (spurious),
        .overflow    (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model state: in-service IDs (bottom first) and sequence phase
    // (0 idle, 1 injecting INC_SP, 2 injecting POP_PC, 3 acknowledging).
    int          stk[$];
    int          phase = 0;
    logic [28:0] e_instr;
    logic        e_inject, e_busy, e_spur, e_ovf;
    logic [7:0]  e_ack;
    int          e_nest;
    bit          cmp_en = 1'b0;

    // Observation logs for the literal checks.
    logic [7:0]  ack_log[$];
    int          inj_cnt = 0;
    int          spur_cnt = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        cmp("instr",      32'(Instruction), 32'(e_instr));
        cmp("inject",     32'(inject),      32'(e_inject));
        cmp("irq_ack",    32'(irq_ack),     32'(e_ack));
        cmp("nest_level", 32'(nest_level),  32'(e_nest));
        cmp("busy",       32'(busy),        32'(e_busy));
        cmp("spurious",   32'(spurious),    32'(e_spur));
        cmp("overflow",   32'(overflow),    32'(e_ovf));
    endtask

    // Predict the outputs after the coming rising edge.
    task automatic model_step(input logic ent, input logic [2:0] id, input logic reti, input logic rst);
        e_ack  = 8'h00;
        e_spur = 1'b0;
        if (rst) begin
            stk.delete();
            phase = 0;
            e_ovf = 1'b0;
        end else begin
            if (phase == 0) begin
                if (reti) begin
                    if (stk.size() > 0) phase = 1;
                    else e_spur = 1'b1;
                end
            end else begin
                e_spur = reti;
                if (phase == 2) begin
                    e_ack = 8'(1) << stk[$];
                    void'(stk.pop_back());
                end
                phase = (phase == 3) ? 0 : phase + 1;
            end
            if (ent) begin
                if (stk.size() < DEPTH) stk.push_back(int'(id));
                else e_ovf = 1'b1;
            end
        end
        e_inject = (phase == 1) || (phase == 2);
        e_instr  = (phase == 1) ? W_INC : ((phase == 2) ? W_POP : W_NOP);
        e_busy   = (phase != 0);
        e_nest   = stk.size();
    endtask

    // One clock: check/log the outputs of the last edge, then drive the next inputs.
    task automatic cyc(input logic ent, input logic [2:0] id, input logic reti, input logic rst);
        @(negedge CLK);
        if (cmp_en) compare_all();
        if (irq_ack !== 8'h00) ack_log.push_back(irq_ack);
        if (inject === 1'b1) inj_cnt++;
        if (spurious === 1'b1) spur_cnt++;
        irq_entered = ent;
        irq_id      = id;
        reti_req    = reti;
        RST         = rst;
        model_step(ent, id, reti, rst);
        if (rst) cmp_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // RETI and wait until the sequencer is idle again.
    task automatic retire();
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        idle(4);
    endtask

    initial begin
        RST = 1'b1; irq_entered = 1'b0; irq_id = 3'd0; reti_req = 1'b0;
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("rst_instr", 32'(Instruction), 32'(W_NOP));
        cmp("rst_nest",  32'(nest_level),  32'd0);
        cmp("rst_ovf",   32'(overflow),    32'd0);

        // Single retire of ID 5.
        inj_cnt = 0; ack_log.delete();
        cyc(1'b1, 3'd5, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("single_inc",     32'(Instruction), 32'(W_INC));
        cmp("single_inject",  32'(inject),      32'd1);
        cmp("single_nest1",   32'(nest_level),  32'd1);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("single_pop",     32'(Instruction), 32'(W_POP));
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("single_ack",     32'(irq_ack),     32'h20);
        cmp("single_nest0",   32'(nest_level),  32'd0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("single_ack_off", 32'(irq_ack),     32'h00);
        cmp("single_idle",    32'(busy),        32'd0);
        cmp("single_inj_len", 32'(inj_cnt),     32'd2);

        // Nesting: 2 then 6, retired 6 then 2.
        ack_log.delete();
        cyc(1'b1, 3'd2, 1'b0, 1'b0);
        cyc(1'b1, 3'd6, 1'b0, 1'b0);
        retire();
        cmp("nest_after1", 32'(nest_level), 32'd1);
        retire();
        cmp("nest_after2", 32'(nest_level), 32'd0);
        cmp("nest_nacks",  32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            cmp("nest_ack0", 32'(ack_log[0]), 32'h40);
            cmp("nest_ack1", 32'(ack_log[1]), 32'h04);
        end

        // Spurious RETI: empty stack, then during POP_PC.
        spur_cnt = 0; ack_log.delete();
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("spur_empty",  32'(spurious), 32'd1);
        cmp("spur_noinj",  32'(inject),   32'd0);
        cmp("spur_noack",  32'(irq_ack),  32'h00);
        cyc(1'b1, 3'd1, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        idle(3);
        cmp("spur_count", 32'(spur_cnt), 32'd2);
        cmp("spur_nacks", 32'(ack_log.size()), 32'd1);
        if (ack_log.size() == 1) cmp("spur_ack", 32'(ack_log[0]), 32'h02);

        // Overflow: five pushes into four entries, then four retires.
        ack_log.delete();
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'(i), 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("ovf_nest", 32'(nest_level), 32'd4);
        cmp("ovf_flag", 32'(overflow),   32'd1);
        for (int i = 0; i < 4; i++) retire();
        cmp("ovf_sticky", 32'(overflow), 32'd1);
        cmp("ovf_nacks",  32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
            cmp("ovf_ack0", 32'(ack_log[0]), 32'h08);
            cmp("ovf_ack1", 32'(ack_log[1]), 32'h04);
            cmp("ovf_ack2", 32'(ack_log[2]), 32'h02);
            cmp("ovf_ack3", 32'(ack_log[3]), 32'h01);
        end

        // Push colliding with the pop: stack {1,3}, push 7 on the ACK edge.
        ack_log.delete();
        cyc(1'b1, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 3'd3, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 3'd7, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("coll_ack",  32'(irq_ack),    32'h08);
        cmp("coll_nest", 32'(nest_level), 32'd2);
        idle(1);
        retire();
        cmp("coll_next_ack", 32'(ack_log[$]), 32'h80);
        retire();
        cmp("coll_last_ack", 32'(ack_log[$]), 32'h02);

        // Push while injecting: the newly nested ID is the one retired.
        cyc(1'b1, 3'd2, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        cyc(1'b1, 3'd5, 1'b0, 1'b0);
        idle(4);
        cmp("inj_push_ack",  32'(ack_log[$]), 32'h20);
        cmp("inj_push_nest", 32'(nest_level), 32'd1);

        // Reset while in POP_PC aborts without an acknowledge.
        ack_log.delete();
        cyc(1'b1, 3'd4, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("rstm_inject", 32'(inject),      32'd0);
        cmp("rstm_instr",  32'(Instruction), 32'(W_NOP));
        cmp("rstm_nest",   32'(nest_level),  32'd0);
        cmp("rstm_ovf",    32'(overflow),    32'd0);
        idle(3);
        cmp("rstm_noack",  32'(ack_log.size()), 32'd0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
